psum_gbf_reader: RTL and testbench
==================================

# psum_gbf_reader

Drains finished partial-sum lines from the psum GBF BRAM that `su_adder` fills, and streams them out as narrow beats with valid/ready flow control. It sits between the psum GBF read port and the output/next-layer path, and absorbs the BRAM's 1-cycle read latency and downstream backpressure. An optional ReLU is applied per 16-bit lane. A transfer is launched by `start`, normally driven after `su_add_finish`.

## Interface

Parameters:

- `GBF_DATA_BITWIDTH`, 512, width of one psum BRAM line.
- `DATA_BITWIDTH`, 16, width of one signed psum lane.
- `OUT_BITWIDTH`, 64, output beat width. Must divide `GBF_DATA_BITWIDTH` and be a multiple of `DATA_BITWIDTH`.
- `ADDR_BITWIDTH`, 10, psum BRAM address width.

Ports:

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_BITWIDTH  first line address; latched on start.
- `num_lines`  in  ADDR_BITWIDTH+1  number of lines to drain; latched on start.
- `relu_en`  in  1  clamp negative lanes to 0; latched on start.
- `rd_en`  out  1  BRAM read enable.
- `rd_addr`  out  ADDR_BITWIDTH  BRAM read address.
- `rd_data`  in  GBF_DATA_BITWIDTH  BRAM read data; valid exactly 1 cycle after `rd_en`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  OUT_BITWIDTH  beat payload.
- `out_last`  out  1  final beat of the final line.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation

- Derived constant: BEATS = GBF_DATA_BITWIDTH / OUT_BITWIDTH (default 8).
- FSM has three states:
  - IDLE: on `start`, latch inputs. If `num_lines` is 0, go to DONE with no reads issued. Otherwise go to RUN.
  - RUN: issue reads and stream beats. Leave for DONE on the handshake of the beat with `out_last`.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Reads:
  - Assert `rd_en` when issued < num_lines and (line buffer occupancy + reads in flight) < 2.
  - `rd_addr` = base_addr + issue index, modulo 2^ADDR_BITWIDTH, so addresses wrap from 1023 to 0.
- Line buffer:
  - 2-entry FIFO of lines, written from `rd_data` one cycle after `rd_en`.
  - It can never overflow by construction. Overflow is an assertion failure.
- Serializer:
  - The head line is sent as BEATS beats, least significant first: beat k = line bits [k*OUT_BITWIDTH +: OUT_BITWIDTH].
  - The beat index advances only on `out_valid && out_ready`.
  - The head entry is popped on the handshake of beat BEATS-1.
- ReLU: when latched `relu_en` is 1, each DATA_BITWIDTH lane is treated as two's complement, and a lane with MSB=1 is output as 0. Otherwise data passes unchanged.
- `start` while `busy` is ignored, and the latched values are not changed.
- Once asserted, `out_valid` and `out_data` hold stable until the handshake completes.

## Timing

- Reset values: `rd_en` 0, `rd_addr` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0. State is IDLE and the FIFO is empty.
- `start` sampled at edge E0:
  - `busy` = 1 and `rd_en` = 1 (address base_addr) during the cycle after E0.
  - The line is captured at E2.
  - `out_valid` = 1 from E2 onward.
  - First-beat latency is 2 cycles.
- With `out_ready` held at 1: one beat per cycle, with no bubbles between lines. The total for N lines is N*BEATS + 2 cycles to the last handshake.
- `done` is high for exactly the cycle after the last handshake. `busy` falls in that same cycle.
- With `num_lines` = 0: `done` is high the cycle after E0, and `busy` never rises.
- Reset asserted mid-transfer:
  - All outputs go to their reset values immediately.
  - The FIFO is flushed.
  - No `done` is produced.
  - An in-flight BRAM read is discarded.

## Structure

- A shared package/header holds the FSM state encoding (IDLE, RUN, DONE), the derived BEATS constant, and the DATA/GBF/ADDR width defaults common with `su_adder`.
- One sub-module, `psum_line_fifo2`: a 2-entry, GBF_DATA_BITWIDTH-wide FIFO with push/pop/count/full/empty. The serializer, ReLU and read issue logic stay in the top level.

## Test plan

- Basic drain:
  - Stimulus: preload BRAM[5] = {32{16'h0001}}; start with base 5, num_lines 1, relu 0, `out_ready` = 1.
  - Required response: 8 beats of 64'h0001000100010001, `out_last` on beat 8, `done` 1 cycle later, first `out_valid` 2 cycles after start.
- Backpressure:
  - Stimulus: 3 lines with `out_ready` toggling 1/0 every cycle.
  - Required response: 24 beats in order, payload stable while stalled, never more than 2 lines buffered.
- ReLU:
  - Stimulus: line lanes alternate 16'hFFFF and 16'h0003, relu 1.
  - Required response: each beat is 64'h0003000000030000; with relu 0 the data passes unchanged.
- Address wrap:
  - Stimulus: base 1022, num_lines 4.
  - Required response: `rd_addr` sequence 1022, 1023, 0, 1; 32 beats total.
- Boundary cases:
  - Stimulus: `num_lines` = 0.
  - Required response: `done` pulse 1 cycle after start, no `rd_en`.
  - Stimulus: `start` re-asserted while busy.
  - Required response: it is ignored.
- Reset abort:
  - Stimulus: pull `reset` low during beat 3 of line 2.
  - Required response: all outputs 0 immediately, no `done`; a new start afterwards drains correctly from the new base.

Source files
------------

// File: rtl/psum_gbf_reader_pkg.sv
// Shared widths, FSM encoding and beat-count helper for the psum GBF reader.
package psum_gbf_reader_pkg;

    localparam int unsigned GBF_DATA_BITWIDTH_DEF = 512;
    localparam int unsigned DATA_BITWIDTH_DEF     = 16;
    localparam int unsigned ADDR_BITWIDTH_DEF     = 10;
    localparam int unsigned OUT_BITWIDTH_DEF      = 64;

    // Number of output beats needed to send one GBF line.
    function automatic int unsigned calc_beats(input int unsigned gbf_w, input int unsigned out_w);
        return gbf_w / out_w;
    endfunction

    localparam int unsigned BEATS_DEF = calc_beats(GBF_DATA_BITWIDTH_DEF, OUT_BITWIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/psum_line_fifo2.sv
// Two-entry line FIFO between the BRAM read port and the beat serializer.
module psum_line_fifo2 #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Line storage; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Read issue throttling must make these impossible.
    a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/psum_gbf_reader.sv
// Drains psum GBF lines through a 2-line buffer and streams them as narrow beats.
module psum_gbf_reader
    import psum_gbf_reader_pkg::*;
#(
    parameter int unsigned GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DEF,
    parameter int unsigned DATA_BITWIDTH     = DATA_BITWIDTH_DEF,
    parameter int unsigned OUT_BITWIDTH      = OUT_BITWIDTH_DEF,
    parameter int unsigned ADDR_BITWIDTH     = ADDR_BITWIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_BITWIDTH-1:0]     base_addr,
    input  logic [ADDR_BITWIDTH:0]       num_lines,
    input  logic                         relu_en,
    output logic                         rd_en,
    output logic [ADDR_BITWIDTH-1:0]     rd_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0] rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_BITWIDTH-1:0]      out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned BEATS  = calc_beats(GBF_DATA_BITWIDTH, OUT_BITWIDTH);
    localparam int unsigned LANES  = OUT_BITWIDTH / DATA_BITWIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = ADDR_BITWIDTH + 1;

    state_t                   state;
    logic [ADDR_BITWIDTH-1:0] base_lat;
    logic [CNT_W-1:0]         n_lat;
    logic [CNT_W-1:0]         issued;
    logic [CNT_W-1:0]         lines_popped;
    logic                     relu_lat;
    logic                     rd_vld;
    logic [BEAT_W-1:0]        beat_idx;

    logic [GBF_DATA_BITWIDTH-1:0] fifo_dout;
    logic [1:0]                   fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;

    logic                    hs;
    logic                    last_beat;
    logic                    last_line;
    logic                    issue_ok;
    logic [OUT_BITWIDTH-1:0] beat_arr [BEATS];
    logic [OUT_BITWIDTH-1:0] beat_raw;

    // A read in flight is either rd_en this cycle or data arriving this cycle.
    assign issue_ok  = (state == ST_RUN) && (issued < n_lat) && !fifo_full &&
                       ((3'(fifo_count) + 3'(rd_en) + 3'(rd_vld)) < 3'd2);
    assign out_valid = (state == ST_RUN) && !fifo_empty;
    assign hs        = out_valid && out_ready;
    assign last_beat = (beat_idx == BEAT_W'(BEATS - 1));
    assign last_line = (lines_popped == n_lat - CNT_W'(1));
    assign out_last  = out_valid && last_beat && last_line;
    assign fifo_pop  = hs && last_beat;

    psum_line_fifo2 #(
        .WIDTH (GBF_DATA_BITWIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_vld),
        .pop   (fifo_pop),
        .din   (rd_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    for (genvar g = 0; g < BEATS; g++) begin : g_beats
        assign beat_arr[g] = fifo_dout[g*OUT_BITWIDTH +: OUT_BITWIDTH];
    end
    assign beat_raw = beat_arr[beat_idx];

    // Beat payload with optional per-lane ReLU; zero whenever no beat is offered.
    always_comb begin
        logic [DATA_BITWIDTH-1:0] lane;
        lane     = '0;
        out_data = '0;
        if (out_valid) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                lane = beat_raw[l*DATA_BITWIDTH +: DATA_BITWIDTH];
                out_data[l*DATA_BITWIDTH +: DATA_BITWIDTH] =
                    (relu_lat && lane[DATA_BITWIDTH-1]) ? '0 : lane;
            end
        end
    end

    // Control FSM, read issue and serializer bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            base_lat     <= '0;
            n_lat        <= '0;
            relu_lat     <= 1'b0;
            issued       <= '0;
            lines_popped <= '0;
            beat_idx     <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            rd_vld       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rd_en <= 1'b0;
                    if (start) begin
                        base_lat     <= base_addr;
                        n_lat        <= num_lines;
                        relu_lat     <= relu_en;
                        lines_popped <= '0;
                        beat_idx     <= '0;
                        if (num_lines == '0) begin
                            issued <= '0;
                            state  <= ST_DONE;
                            done   <= 1'b1;
                        end else begin
                            issued  <= CNT_W'(1);
                            rd_en   <= 1'b1;
                            rd_addr <= base_addr;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rd_en <= issue_ok;
                    if (issue_ok) begin
                        rd_addr <= base_lat + issued[ADDR_BITWIDTH-1:0];
                        issued  <= issued + CNT_W'(1);
                    end
                    if (hs) begin
                        beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
                        if (last_beat) begin
                            lines_popped <= lines_popped + CNT_W'(1);
                        end
                        if (out_last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rd_en <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    rd_en <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_gbf_reader.sv
// Randomized self-checking bench for psum_gbf_reader with a BRAM model and beat scoreboard.
module tb_psum_gbf_reader;

    localparam int unsigned GBF   = 512;
    localparam int unsigned DW    = 16;
    localparam int unsigned OW    = 64;
    localparam int unsigned AW    = 10;
    localparam int unsigned NW    = AW + 1;
    localparam int unsigned BEATS = GBF / OW;
    localparam int unsigned LANES = OW / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [NW-1:0] num_lines;
    logic          relu_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [GBF-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0;

    logic [GBF-1:0] mem [0:1023];
    logic [OW-1:0]  exp_q [$];

    // Monitor state
    logic [OW-1:0] cap_data [$];
    bit            cap_last [$];
    int            cap_cyc  [$];
    int            addr_q   [$];
    int            done_cnt, done_cyc, busy_seen, stall_err, max_out, reads, lines_done;
    bit            prev_stall;
    logic [OW-1:0] prev_data;
    bit            mon_clr = 1'b0;

    psum_gbf_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .relu_en   (relu_en),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Observe handshakes, reads and status on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                cap_data.delete(); cap_last.delete(); cap_cyc.delete(); addr_q.delete();
                done_cnt = 0; done_cyc = -1; busy_seen = 0; stall_err = 0;
                max_out = 0; reads = 0; lines_done = 0; prev_stall = 1'b0;
            end else if (reset) begin
                if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (rd_en) begin addr_q.push_back(int'(rd_addr)); reads++; end
                if (busy) busy_seen++;
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (out_valid && out_ready) begin
                    cap_data.push_back(out_data);
                    cap_last.push_back(out_last);
                    cap_cyc.push_back(cyc);
                    if (cap_data.size() % BEATS == 0) lines_done++;
                end
                if (reads - lines_done > max_out) max_out = reads - lines_done;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic fill_rand(input int b, input int n);
        for (int i = 0; i < n; i++)
            for (int w = 0; w < int'(GBF / 32); w++)
                mem[(b + i) % 1024][w*32 +: 32] = $urandom;
    endtask

    // Reference: line i comes from address (base+i) mod 1024, sliced LSB first, lanes clamped.
    task automatic model_expect(input int b, input int n, input bit relu);
        logic [GBF-1:0] line;
        logic [OW-1:0]  beat;
        logic [DW-1:0]  lane;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            line = mem[(b + i) % 1024];
            for (int k = 0; k < int'(BEATS); k++) begin
                beat = line[k*OW +: OW];
                if (relu)
                    for (int l = 0; l < int'(LANES); l++) begin
                        lane = beat[l*DW +: DW];
                        if ($signed(lane) < 0) beat[l*DW +: DW] = '0;
                    end
                exp_q.push_back(beat);
            end
        end
    endtask

    task automatic do_start(input int b, input int n, input bit relu);
        base_addr = AW'(b);
        num_lines = NW'(n);
        relu_en   = relu;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        t0        = cyc;
    endtask

    // mode 0: ready high, 1: toggle each cycle, 2: random
    task automatic drain(input int budget, input int mode, input int restart_at, input string name);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (i == restart_at);
            if (i == restart_at) begin
                base_addr = AW'($urandom);
                num_lines = NW'($urandom_range(1, 7));
                relu_en   = ~relu_en;
            end
            tick();
            i++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL %s_timeout: done count 0 after %0d cycles, required 1", name, budget);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0; relu_en = 1'b0; out_ready = 1'b1;
        rd_data = '0;
        repeat (2) tick();
        n_cmp++;
        if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got %h, required 0", {rd_en, rd_addr, out_valid, out_data, out_last, busy, done});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({rd_en, out_valid, busy, done} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got %b, required 0000", {rd_en, out_valid, busy, done});
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        mem[5] = {32{16'h0001}};
        clear_mon();
        model_expect(5, 1, 1'b0);
        out_ready = 1'b1;
        do_start(5, 1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== AW'(5)) begin
            n_bad++;
            $display("FAIL basic_first_read: busy %b rd_en %b addr %0d, required 1 1 5", busy, rd_en, rd_addr);
        end
        tick();
        drain(60, 0, -1, "basic");
        foreach (exp_q[i])
            if (i >= cap_data.size() || cap_data[i] !== 64'h0001000100010001 || cap_data[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != 8) begin
            n_bad++;
            $display("FAIL basic_beats: %0d wrong of %0d received, required 0 wrong of 8", bad, cap_data.size());
        end
        n_cmp++;
        if (cap_last.size() != 8 || cap_last[7] !== 1'b1 || cap_last.sum() with (int'(item)) != 1) begin
            n_bad++;
            $display("FAIL basic_last: %0d last flags over %0d beats, required one on beat 8", cap_last.sum() with (int'(item)), cap_last.size());
        end
        n_cmp++;
        if (cap_cyc.size() == 0 || cap_cyc[0] - t0 != 2) begin
            n_bad++;
            $display("FAIL basic_latency: first beat %0d cycles after start, required 2", cap_cyc.size() ? cap_cyc[0] - t0 : -1);
        end
        n_cmp++;
        if (done_cnt != 1 || cap_cyc.size() == 0 || done_cyc != cap_cyc[cap_cyc.size()-1] + 1 || done_cyc - t0 != 10) begin
            n_bad++;
            $display("FAIL basic_done: %0d pulses at +%0d, required 1 pulse at +10", done_cnt, done_cyc - t0);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int b = int'($urandom_range(0, 1023));
        fill_rand(b, 3);
        clear_mon();
        model_expect(b, 3, 1'b0);
        do_start(b, 3, 1'b0);
        drain(200, 1, -1, "bp");
        foreach (exp_q[i]) if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != 24) begin
            n_bad++;
            $display("FAIL bp_beats: %0d wrong of %0d received, required 0 wrong of 24", bad, cap_data.size());
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d payload changes while stalled, required 0", stall_err);
        end
        n_cmp++;
        if (max_out > 2) begin
            n_bad++;
            $display("FAIL bp_buffered: %0d lines outstanding, required at most 2", max_out);
        end
    endtask

    task automatic test_relu();
        int bad = 0;
        int b = int'($urandom_range(0, 1022));
        for (int pass = 0; pass < 2; pass++) begin
            bad = 0;
            mem[b] = {16{16'h0003, 16'hFFFF}};
            mem[b + 1] = {16{16'h0003, 16'hFFFF}};
            clear_mon();
            model_expect(b, 2, pass == 0);
            do_start(b, 2, pass == 0);
            drain(80, 2, -1, "relu");
            foreach (exp_q[i])
                if (i >= cap_data.size() || cap_data[i] !== exp_q[i] ||
                    cap_data[i] !== (pass == 0 ? 64'h0003000000030000 : 64'h0003FFFF0003FFFF)) bad++;
            n_cmp++;
            if (bad != 0 || cap_data.size() != 16) begin
                n_bad++;
                $display("FAIL relu%0d_beats: %0d wrong of %0d received, required 0 wrong of 16", 1 - pass, bad, cap_data.size());
            end
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        fill_rand(1022, 4);
        clear_mon();
        model_expect(1022, 4, 1'b1);
        do_start(1022, 4, 1'b1);
        drain(100, 0, -1, "wrap");
        n_cmp++;
        if (addr_q.size() != 4 || addr_q[0] != 1022 || addr_q[1] != 1023 || addr_q[2] != 0 || addr_q[3] != 1) begin
            n_bad++;
            $display("FAIL wrap_addr: got %p, required 1022 1023 0 1", addr_q);
        end
        foreach (exp_q[i]) if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != 32) begin
            n_bad++;
            $display("FAIL wrap_beats: %0d wrong of %0d received, required 0 wrong of 32", bad, cap_data.size());
        end
        n_cmp++;
        if (done_cyc - t0 != 4 * int'(BEATS) + 2) begin
            n_bad++;
            $display("FAIL wrap_throughput: done at +%0d, required +%0d", done_cyc - t0, 4 * BEATS + 2);
        end
    endtask

    task automatic test_zero_lines();
        clear_mon();
        do_start(int'($urandom_range(0, 1023)), 0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done: done %b the cycle after start, required 1", done);
        end
        tick();
        repeat (4) tick();
        n_cmp++;
        if (done_cnt != 1 || reads != 0 || busy_seen != 0 || done_cyc != t0) begin
            n_bad++;
            $display("FAIL zero_quiet: done %0d reads %0d busy %0d, required 1 0 0", done_cnt, reads, busy_seen);
        end
    endtask

    task automatic test_restart_ignored();
        int bad = 0;
        int b = int'($urandom_range(0, 1023));
        fill_rand(b, 3);
        clear_mon();
        model_expect(b, 3, 1'b0);
        do_start(b, 3, 1'b0);
        drain(120, 0, 6, "restart");
        foreach (exp_q[i]) if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != 24 || addr_q.size() != 3 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL restart_ignored: %0d wrong, %0d beats, %0d reads, %0d done; required 0 24 3 1",
                     bad, cap_data.size(), addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        int i = 0;
        int b = int'($urandom_range(0, 1023));
        fill_rand(b, 3);
        clear_mon();
        out_ready = 1'b1;
        do_start(b, 3, 1'b0);
        while (cap_data.size() < int'(BEATS) + 2 && i < 60) begin tick(); i++; end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %h, required 0", {rd_en, rd_addr, out_valid, out_data, out_last, busy, done});
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: done %0d busy %b, required 0 0", done_cnt, busy);
        end
        b = (b + 512) % 1024;
        fill_rand(b, 2);
        clear_mon();
        model_expect(b, 2, 1'b1);
        do_start(b, 2, 1'b1);
        drain(80, 0, -1, "abort");
        foreach (exp_q[k]) if (k >= cap_data.size() || cap_data[k] !== exp_q[k]) bad++;
        n_cmp++;
        if (bad != 0 || cap_data.size() != 16) begin
            n_bad++;
            $display("FAIL abort_redrain: %0d wrong of %0d received, required 0 wrong of 16", bad, cap_data.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int bad = 0;
            int b   = int'($urandom_range(0, 1023));
            int n   = int'($urandom_range(1, 5));
            bit r   = 1'($urandom_range(0, 1));
            fill_rand(b, n);
            clear_mon();
            model_expect(b, n, r);
            do_start(b, n, r);
            drain(n * int'(BEATS) * 6 + 40, 2, -1, "rand");
            foreach (exp_q[i]) if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) bad++;
            n_cmp++;
            if (bad != 0 || cap_data.size() != n * int'(BEATS) || done_cnt != 1 ||
                stall_err != 0 || max_out > 2) begin
                n_bad++;
                $display("FAIL rand%0d: %0d wrong, %0d beats (need %0d), done %0d, stall %0d, outstanding %0d",
                         it, bad, cap_data.size(), n * BEATS, done_cnt, stall_err, max_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_relu();
        test_wrap();
        test_zero_lines();
        test_restart_ignored();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
